// File: rtl/debug_commit_queue.sv
// Commit-trace queue: captures up to two retiring register writes per cycle
// and hands them to a debug consumer in program order through a valid/ready head.
module debug_commit_queue #(
    parameter int          DEPTH  = 8,
    parameter logic [31:0] END_PC = 32'hbfc00100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              wb_pc0,
    input  logic [31:0]              wb_pc1,
    input  logic [3:0]               wb_rf_wen0,
    input  logic [3:0]               wb_rf_wen1,
    input  logic [4:0]               wb_rf_wnum0,
    input  logic [4:0]               wb_rf_wnum1,
    input  logic [31:0]              wb_rf_wdata0,
    input  logic [31:0]              wb_rf_wdata1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [3:0]               out_wen,
    output logic [4:0]               out_wnum,
    output logic [31:0]              out_wdata,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     end_seen
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } entry_t;

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             end_seen_r;

    entry_t           slot0_s;
    entry_t           slot1_s;
    entry_t           head_s;
    logic [PTR_W-1:0] wr_ptr1_s;
    logic [CNT_W-1:0] space_s;
    logic [CNT_W-1:0] count_next_s;
    logic             q0_s;
    logic             q1_s;
    logic             pop_s;
    logic             push0_s;
    logic             push1_s;
    logic             drop_s;
    logic             end_hit_s;

    assign slot0_s = '{pc: wb_pc0, wen: wb_rf_wen0, wnum: wb_rf_wnum0, wdata: wb_rf_wdata0};
    assign slot1_s = '{pc: wb_pc1, wen: wb_rf_wen1, wnum: wb_rf_wnum1, wdata: wb_rf_wdata1};

    // Qualification, space accounting (a pop frees a slot in the same cycle) and push/drop decisions
    always_comb begin
        q0_s      = (|wb_rf_wen0) && (wb_rf_wnum0 != 5'd0) && !end_seen_r;
        q1_s      = (|wb_rf_wen1) && (wb_rf_wnum1 != 5'd0) && !end_seen_r;
        pop_s     = (count_r != {CNT_W{1'b0}}) && out_ready;
        space_s   = CNT_W'(DEPTH) - count_r + CNT_W'(pop_s);
        push0_s   = q0_s && (space_s != {CNT_W{1'b0}});
        if (push0_s) begin
            push1_s = q1_s && (space_s >= CNT_W'(2));
        end else begin
            push1_s = q1_s && (space_s != {CNT_W{1'b0}});
        end
        if (push0_s) begin
            wr_ptr1_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr1_s = wr_ptr_r;
        end
        drop_s       = (q0_s && !push0_s) || (q1_s && !push1_s);
        count_next_s = count_r + CNT_W'(push0_s) + CNT_W'(push1_s) - CNT_W'(pop_s);
        end_hit_s    = (wb_pc0 == END_PC) || (wb_pc1 == END_PC);
        if (count_r != {CNT_W{1'b0}}) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    // Control state: pointers, occupancy and sticky status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
            end_seen_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_r + PTR_W'(push0_s) + PTR_W'(push1_s);
            rd_ptr_r   <= rd_ptr_r + PTR_W'(pop_s);
            count_r    <= count_next_s;
            overflow_r <= overflow_r | drop_s;
            end_seen_r <= end_seen_r | end_hit_s;
        end
    end

    // Entry storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (!reset && push0_s) begin
            mem_r[wr_ptr_r] <= slot0_s;
        end
        if (!reset && push1_s) begin
            mem_r[wr_ptr1_s] <= slot1_s;
        end
    end

    assign out_valid = (count_r != {CNT_W{1'b0}});
    assign out_pc    = head_s.pc;
    assign out_wen   = head_s.wen;
    assign out_wnum  = head_s.wnum;
    assign out_wdata = head_s.wdata;
    assign stall_req = (CNT_W'(DEPTH) - count_r) < CNT_W'(2);
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign end_seen  = end_seen_r;

endmodule

// File: tb/tb_debug_commit_queue.sv
// Bench for debug_commit_queue: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_debug_commit_queue;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] END_PC = 32'hbfc00100;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } entry_t;

    typedef struct {
        logic        rst;
        logic [31:0] pc0;  logic [3:0] wen0; logic [4:0] wnum0; logic [31:0] wd0;
        logic [31:0] pc1;  logic [3:0] wen1; logic [4:0] wnum1; logic [31:0] wd1;
        logic        rdy;
        int          e_cnt; logic e_vld; logic [31:0] e_pc; logic [3:0] e_wen;
        logic [4:0]  e_wnum; logic [31:0] e_wd; logic e_stall; logic e_ovf;
    } tv_t;

    logic        clk;
    logic        reset;
    logic [31:0] wb_pc0, wb_pc1, wb_rf_wdata0, wb_rf_wdata1;
    logic [3:0]  wb_rf_wen0, wb_rf_wen1;
    logic [4:0]  wb_rf_wnum0, wb_rf_wnum1;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_wdata;
    logic [3:0]  out_wen;
    logic [4:0]  out_wnum;
    logic        stall_req, overflow, end_seen;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    entry_t mq[$];
    bit     m_ovf;
    bit     m_end;
    tv_t    tv[8];

    debug_commit_queue #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
        .clk(clk), .reset(reset),
        .wb_pc0(wb_pc0), .wb_pc1(wb_pc1),
        .wb_rf_wen0(wb_rf_wen0), .wb_rf_wen1(wb_rf_wen1),
        .wb_rf_wnum0(wb_rf_wnum0), .wb_rf_wnum1(wb_rf_wnum1),
        .wb_rf_wdata0(wb_rf_wdata0), .wb_rf_wdata1(wb_rf_wdata1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_wen(out_wen), .out_wnum(out_wnum), .out_wdata(out_wdata),
        .stall_req(stall_req), .count(count), .overflow(overflow), .end_seen(end_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic set0(input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] wnum, input logic [31:0] wd);
        wb_pc0 = pc; wb_rf_wen0 = wen; wb_rf_wnum0 = wnum; wb_rf_wdata0 = wd;
    endtask

    task automatic set1(input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] wnum, input logic [31:0] wd);
        wb_pc1 = pc; wb_rf_wen1 = wen; wb_rf_wnum1 = wnum; wb_rf_wdata1 = wd;
    endtask

    task automatic idle();
        set0(32'h0, 4'h0, 5'd0, 32'h0);
        set1(32'h0, 4'h0, 5'd0, 32'h0);
    endtask

    // Reference: pop first, then accept qualifying slots in order while room remains.
    task automatic model_update();
        bit qual0, qual1;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_end = 1'b0;
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            qual0 = (wb_rf_wen0 != 4'h0) && (wb_rf_wnum0 != 5'd0) && !m_end;
            qual1 = (wb_rf_wen1 != 4'h0) && (wb_rf_wnum1 != 5'd0) && !m_end;
            if (qual0) begin
                if (mq.size() < DEPTH) mq.push_back('{wb_pc0, wb_rf_wen0, wb_rf_wnum0, wb_rf_wdata0});
                else m_ovf = 1'b1;
            end
            if (qual1) begin
                if (mq.size() < DEPTH) mq.push_back('{wb_pc1, wb_rf_wen1, wb_rf_wnum1, wb_rf_wdata1});
                else m_ovf = 1'b1;
            end
            if (wb_pc0 == END_PC || wb_pc1 == END_PC) m_end = 1'b1;
        end
    endtask

    task automatic compare_model(input string nm);
        entry_t hd;
        hd = (mq.size() > 0) ? mq[0] : '0;
        chk({nm, ".count"},    32'(count),     32'(mq.size()));
        chk({nm, ".valid"},    32'(out_valid), 32'(mq.size() != 0));
        chk({nm, ".pc"},       out_pc,         hd.pc);
        chk({nm, ".wen"},      32'(out_wen),   32'(hd.wen));
        chk({nm, ".wnum"},     32'(out_wnum),  32'(hd.wnum));
        chk({nm, ".wdata"},    out_wdata,      hd.wdata);
        chk({nm, ".stall"},    32'(stall_req), 32'((DEPTH - mq.size()) < 2));
        chk({nm, ".overflow"}, 32'(overflow),  32'(m_ovf));
        chk({nm, ".end_seen"}, 32'(end_seen),  32'(m_end));
    endtask

    task automatic step(input string nm);
        model_update();
        @(posedge clk);
        #1;
        compare_model(nm);
    endtask

    task automatic do_reset();
        reset = 1'b1; out_ready = 1'b0; idle();
        step("rst");
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0; idle();
        m_ovf = 1'b0; m_end = 1'b0;

        tv[0] = '{1'b1, 32'h0, 4'h0, 5'd0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0,
                  0, 1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 32'hbfc00000, 4'hf, 5'd2, 32'h11, 32'hbfc00004, 4'hf, 5'd3, 32'h22, 1'b0,
                  2, 1'b1, 32'hbfc00000, 4'hf, 5'd2, 32'h11, 1'b0, 1'b0};
        tv[2] = '{1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b1,
                  1, 1'b1, 32'hbfc00004, 4'hf, 5'd3, 32'h22, 1'b0, 1'b0};
        tv[3] = '{1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b1,
                  0, 1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b0};
        tv[4] = '{1'b0, 32'h100, 4'hf, 5'd0, 32'h33, 32'h104, 4'h0, 5'd5, 32'h44, 1'b0,
                  0, 1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b0};
        tv[5] = '{1'b0, 32'h108, 4'h0, 5'd3, 32'h55, 32'hbfc00010, 4'hf, 5'd7, 32'h77, 1'b0,
                  1, 1'b1, 32'hbfc00010, 4'hf, 5'd7, 32'h77, 1'b0, 1'b0};
        tv[6] = '{1'b0, 32'hbfc00014, 4'h3, 5'd9, 32'haabbccdd, 32'h0, 4'h0, 5'd0, 32'h0, 1'b1,
                  1, 1'b1, 32'hbfc00014, 4'h3, 5'd9, 32'haabbccdd, 1'b0, 1'b0};
        tv[7] = '{1'b1, 32'hbfc00020, 4'hf, 5'd1, 32'h1, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0,
                  0, 1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("tv%0d", i);
            reset = tv[i].rst; out_ready = tv[i].rdy;
            set0(tv[i].pc0, tv[i].wen0, tv[i].wnum0, tv[i].wd0);
            set1(tv[i].pc1, tv[i].wen1, tv[i].wnum1, tv[i].wd1);
            step(nm);
            chk({nm, ".t_count"}, 32'(count),     32'(tv[i].e_cnt));
            chk({nm, ".t_valid"}, 32'(out_valid), 32'(tv[i].e_vld));
            chk({nm, ".t_pc"},    out_pc,         tv[i].e_pc);
            chk({nm, ".t_wen"},   32'(out_wen),   32'(tv[i].e_wen));
            chk({nm, ".t_wnum"},  32'(out_wnum),  32'(tv[i].e_wnum));
            chk({nm, ".t_wdata"}, out_wdata,      tv[i].e_wd);
            chk({nm, ".t_stall"}, 32'(stall_req), 32'(tv[i].e_stall));
            chk({nm, ".t_ovf"},   32'(overflow),  32'(tv[i].e_ovf));
        end
        reset = 1'b0;

        // Full boundary
        do_reset();
        for (int i = 0; i < 7; i++) begin
            idle();
            set0(32'h1000 + 32'(i) * 32'd4, 4'hf, 5'(i + 1), 32'(i) + 32'h500);
            step("fill");
            if (i == 5) chk("full.stall_at6", 32'(stall_req), 32'd0);
        end
        chk("full.count7", 32'(count), 32'd7);
        chk("full.stall7", 32'(stall_req), 32'd1);
        set0(32'h2000, 4'hf, 5'd10, 32'haaaa);
        set1(32'h2004, 4'hf, 5'd11, 32'hbbbb);
        step("full_dual");
        chk("full.count8", 32'(count), 32'd8);
        chk("full.ovf", 32'(overflow), 32'd1);
        set0(32'h2008, 4'hf, 5'd12, 32'hcccc);
        set1(32'h200c, 4'hf, 5'd13, 32'hdddd);
        out_ready = 1'b1;
        step("full_pop");
        chk("full.count8_pop", 32'(count), 32'd8);
        chk("full.ovf_sticky", 32'(overflow), 32'd1);

        // Wrap-around streaming
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle();
            set1(32'h3000 + 32'(i) * 32'd4, 4'hf, 5'(i % 31 + 1), 32'(i) * 32'd3);
            step("wrap");
            chk("wrap.cnt_le1", 32'(count <= 4'd1), 32'd1);
        end
        idle();
        step("wrap_tail");
        chk("wrap.ovf", 32'(overflow), 32'd0);

        // End of test marker
        do_reset();
        for (int i = 0; i < 2; i++) begin
            idle();
            set0(32'h4000 + 32'(i) * 32'd4, 4'hf, 5'd6, 32'(i));
            step("end_pre");
        end
        idle();
        set1(END_PC, 4'hf, 5'd4, 32'h4444);
        step("end_hit");
        chk("end.count3", 32'(count), 32'd3);
        chk("end.seen", 32'(end_seen), 32'd1);
        set0(32'h5000, 4'hf, 5'd8, 32'h8);
        set1(32'h5004, 4'hf, 5'd9, 32'h9);
        step("end_block");
        chk("end.blocked", 32'(count), 32'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("end_drain");
        chk("end.drained", 32'(count), 32'd0);
        chk("end.valid0", 32'(out_valid), 32'd0);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            set0(32'h6000 + 32'(i) * 32'd4, 4'h1, 5'd3, 32'(i));
            step("mid_fill");
        end
        reset = 1'b1;
        set0(32'h7000, 4'hf, 5'd3, 32'h7);
        step("mid_rst");
        reset = 1'b0;
        chk("mid.count0", 32'(count), 32'd0);
        chk("mid.valid0", 32'(out_valid), 32'd0);
        chk("mid.ovf0", 32'(overflow), 32'd0);
        chk("mid.end0", 32'(end_seen), 32'd0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 99) < 2);
            out_ready = ($urandom_range(0, 9) < 6);
            set0($urandom, 4'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
            set1($urandom, 4'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
            if ($urandom_range(0, 99) == 0) wb_pc1 = END_PC;
            step("rand");
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
